// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl
//   Keypad/card front-end for the ATM core. Walks a session through PIN entry,
//   operation select, amount or new-PIN entry, then holds a request to the core
//   until it answers. Tracks consecutive PIN failures (card retention) and an
//   inactivity timer (card eject).
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   card_in             card present level; rising edge starts a session
//   card_acc, lang_sel  account number / language, latched on card insertion
//   key_valid, key_code one-cycle key strobe; 0-9 digit, A enter, B clear, C cancel
//   core_resp_valid     core result strobe with core_success / core_pin_ok
//   operation, acc_num, pin, Newpin, amount, language   request fields to the core
//   txn_valid           request valid, held until the core responds
//   txn_ok, card_eject, card_retain, timeout            one-cycle event pulses
module atm_session_ctrl #(
   parameter int         MAX_PIN_TRIES  = 3,
   parameter int         TIMEOUT_CYCLES = 1000,
   parameter logic [2:0] OP_WITHDRAW    = 3'd2,
   parameter logic [2:0] OP_DEPOSIT     = 3'd3,
   parameter logic [2:0] OP_CHPIN       = 3'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        card_in,
   input  logic [3:0]  card_acc,
   input  logic        lang_sel,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        core_resp_valid,
   input  logic        core_success,
   input  logic        core_pin_ok,
   output logic [2:0]  operation,
   output logic [3:0]  acc_num,
   output logic        language,
   output logic [15:0] pin,
   output logic [15:0] Newpin,
   output logic [15:0] amount,
   output logic        txn_valid,
   output logic        txn_ok,
   output logic        card_eject,
   output logic        card_retain,
   output logic        timeout
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int FW = $clog2(MAX_PIN_TRIES + 1);

   typedef enum logic [2:0] {
      IDLE, PIN, OPSEL, AMT, NEWPIN, WAIT, EJECT, RETAIN
   } state_t;

   state_t        state;
   logic          card_q;
   logic [2:0]    cnt;       // digits entered in the current field
   logic          op_set;    // an op digit has been keyed since entering OPSEL
   logic [FW-1:0] fail_cnt;
   logic [TW-1:0] timer;

   logic          card_rise, card_fall;
   logic          is_digit, is_enter, is_clear, is_cancel;
   logic          active, expired;
   logic [16:0]   amt_ext;
   logic [15:0]   amt_next;
   logic [FW-1:0] fail_next;

   always_comb begin
      card_rise = card_in & ~card_q;
      card_fall = ~card_in & card_q;
      is_digit  = key_valid && (key_code <= 4'd9);
      is_enter  = key_valid && (key_code == 4'hA);
      is_clear  = key_valid && (key_code == 4'hB);
      is_cancel = key_valid && (key_code == 4'hC);
      active    = (state == PIN) || (state == OPSEL) || (state == AMT) ||
                  (state == NEWPIN) || (state == WAIT);
      // A key in the expiring cycle counts as activity and restarts the timer.
      expired   = active && !key_valid && (timer == TW'(TIMEOUT_CYCLES - 1));
      amt_ext   = 17'(amount) * 17'd10 + 17'(key_code);
      amt_next  = (amt_ext > 17'd9999) ? 16'd9999 : amt_ext[15:0];
      fail_next = fail_cnt + FW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         card_q      <= 1'b0;
         cnt         <= '0;
         op_set      <= 1'b0;
         fail_cnt    <= '0;
         timer       <= '0;
         operation   <= '0;
         acc_num     <= '0;
         language    <= 1'b0;
         pin         <= '0;
         Newpin      <= '0;
         amount      <= '0;
         txn_valid   <= 1'b0;
         txn_ok      <= 1'b0;
         card_eject  <= 1'b0;
         card_retain <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         card_q      <= card_in;
         txn_ok      <= 1'b0;
         card_eject  <= 1'b0;
         card_retain <= 1'b0;
         timeout     <= 1'b0;
         if (active)    timer <= timer + TW'(1);
         if (key_valid) timer <= '0;

         if (active && card_fall) begin
            txn_valid <= 1'b0;
            timer     <= '0;
            state     <= EJECT;
         end else if (state == WAIT && core_resp_valid) begin
            // Response beats a same-cycle key; WAIT ignores keys anyway.
            txn_valid <= 1'b0;
            timer     <= '0;
            cnt       <= '0;
            if (!core_pin_ok) begin
               fail_cnt <= fail_next;
               if (fail_next >= FW'(MAX_PIN_TRIES)) begin
                  state <= RETAIN;
               end else begin
                  pin   <= '0;
                  state <= PIN;
               end
            end else begin
               fail_cnt  <= '0;
               txn_ok    <= core_success;
               amount    <= '0;
               Newpin    <= '0;
               operation <= '0;
               op_set    <= 1'b0;
               state     <= OPSEL;
            end
         end else if (expired) begin
            timeout   <= 1'b1;
            txn_valid <= 1'b0;
            timer     <= '0;
            state     <= EJECT;
         end else begin
            case (state)
               IDLE: if (card_rise) begin
                  acc_num  <= card_acc;
                  language <= lang_sel;
                  pin      <= '0;
                  Newpin   <= '0;
                  amount   <= '0;
                  cnt      <= '0;
                  timer    <= '0;
                  state    <= PIN;
               end
               PIN: begin
                  if (is_cancel) begin
                     timer <= '0;
                     state <= EJECT;
                  end else if (is_clear) begin
                     pin <= '0;
                     cnt <= '0;
                  end else if (is_digit && cnt < 3'd4) begin
                     pin <= {pin[11:0], key_code};
                     cnt <= cnt + 3'd1;
                  end else if (is_enter && cnt == 3'd4) begin
                     cnt    <= '0;
                     op_set <= 1'b0;
                     timer  <= '0;
                     state  <= OPSEL;
                  end
               end
               OPSEL: begin
                  if (is_cancel) begin
                     timer <= '0;
                     state <= EJECT;
                  end else if (is_digit && key_code <= 4'd7) begin
                     operation <= key_code[2:0];
                     op_set    <= 1'b1;
                  end else if (is_enter && op_set) begin
                     timer <= '0;
                     cnt   <= '0;
                     if (operation == OP_WITHDRAW || operation == OP_DEPOSIT) begin
                        amount <= '0;
                        state  <= AMT;
                     end else if (operation == OP_CHPIN) begin
                        Newpin <= '0;
                        state  <= NEWPIN;
                     end else begin
                        txn_valid <= 1'b1;
                        state     <= WAIT;
                     end
                  end
               end
               AMT: begin
                  if (is_cancel) begin
                     timer <= '0;
                     state <= EJECT;
                  end else if (is_clear) begin
                     amount <= '0;
                     cnt    <= '0;
                  end else if (is_digit && cnt < 3'd4) begin
                     amount <= amt_next;
                     cnt    <= cnt + 3'd1;
                  end else if (is_enter && amount != 16'd0) begin
                     txn_valid <= 1'b1;
                     timer     <= '0;
                     state     <= WAIT;
                  end
               end
               NEWPIN: begin
                  if (is_cancel) begin
                     timer <= '0;
                     state <= EJECT;
                  end else if (is_clear) begin
                     Newpin <= '0;
                     cnt    <= '0;
                  end else if (is_digit && cnt < 3'd4) begin
                     Newpin <= {Newpin[11:0], key_code};
                     cnt    <= cnt + 3'd1;
                  end else if (is_enter && cnt == 3'd4) begin
                     txn_valid <= 1'b1;
                     timer     <= '0;
                     state     <= WAIT;
                  end
               end
               WAIT: ;
               EJECT, RETAIN: begin
                  card_eject  <= (state == EJECT);
                  card_retain <= (state == RETAIN);
                  pin         <= '0;
                  Newpin      <= '0;
                  amount      <= '0;
                  operation   <= '0;
                  fail_cnt    <= '0;
                  cnt         <= '0;
                  op_set      <= 1'b0;
                  timer       <= '0;
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl
//   Table of {inputs, expected outputs} rows plus hand-written sequences for
//   the inactivity timeout and an asynchronous reset during WAIT. Each driven
//   row pushes its expected outputs; a monitor pops one per clock edge.
module tb_atm_session_ctrl;

   logic        clk, rst_n, card_in, lang_sel, key_valid;
   logic [3:0]  card_acc, key_code;
   logic        core_resp_valid, core_success, core_pin_ok;
   logic [2:0]  operation;
   logic [3:0]  acc_num;
   logic        language, txn_valid, txn_ok, card_eject, card_retain, timeout;
   logic [15:0] pin, Newpin, amount;

   atm_session_ctrl dut (
      .clk(clk), .rst_n(rst_n), .card_in(card_in), .card_acc(card_acc),
      .lang_sel(lang_sel), .key_valid(key_valid), .key_code(key_code),
      .core_resp_valid(core_resp_valid), .core_success(core_success),
      .core_pin_ok(core_pin_ok), .operation(operation), .acc_num(acc_num),
      .language(language), .pin(pin), .Newpin(Newpin), .amount(amount),
      .txn_valid(txn_valid), .txn_ok(txn_ok), .card_eject(card_eject),
      .card_retain(card_retain), .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       card;
      logic [3:0] acc_in;
      logic       lang_in;
      logic       kv;
      logic [3:0] kc;
      logic       rv, succ, pok;
   } in_t;

   typedef struct packed {
      logic [15:0] pin, np, amt;
      logic [2:0]  op;
      logic [3:0]  acc;
      logic        lang, tv, ok, ej, rt, to;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   localparam logic [4:0] NK = 5'b00000;
   localparam logic [2:0] R0 = 3'b000, RS = 3'b111, RF = 3'b101, RP = 3'b100;
   localparam logic [4:0] P0 = 5'b00000, TV = 5'b10000, OK = 5'b01000,
                          EJ = 5'b00100, RT = 5'b00010, TO = 5'b00001;

   int         n_vec = 0, n_err = 0;
   logic [3:0] t_acc = 4'd0;
   logic       t_lang = 1'b0;
   vec_t       tbl[$];
   string      tnm[$];
   out_t       sb[$];
   string      sbn[$];
   int         wait_cyc;
   bit         to_seen;

   function automatic logic [4:0] k(input logic [3:0] c);
      return {1'b1, c};
   endfunction

   function automatic vec_t mk(input bit card, input logic [4:0] key, input logic [2:0] rsp,
                               input logic [15:0] p, input logic [2:0] op,
                               input logic [15:0] amt, input logic [15:0] np,
                               input logic [4:0] pul);
      vec_t x;
      x.i.card = card; x.i.acc_in = t_acc; x.i.lang_in = t_lang;
      {x.i.kv, x.i.kc} = key;
      {x.i.rv, x.i.succ, x.i.pok} = rsp;
      x.o.pin = p; x.o.np = np; x.o.amt = amt; x.o.op = op;
      x.o.acc = t_acc; x.o.lang = t_lang;
      {x.o.tv, x.o.ok, x.o.ej, x.o.rt, x.o.to} = pul;
      return x;
   endfunction

   function automatic out_t cur_out();
      out_t o;
      o.pin = pin; o.np = Newpin; o.amt = amount; o.op = operation;
      o.acc = acc_num; o.lang = language; o.tv = txn_valid; o.ok = txn_ok;
      o.ej = card_eject; o.rt = card_retain; o.to = timeout;
      return o;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   task automatic apply(input vec_t x, input string nm);
      @(negedge clk);
      card_in = x.i.card; card_acc = x.i.acc_in; lang_sel = x.i.lang_in;
      key_valid = x.i.kv; key_code = x.i.kc;
      core_resp_valid = x.i.rv; core_success = x.i.succ; core_pin_ok = x.i.pok;
      sb.push_back(x.o);
      sbn.push_back(nm);
   endtask

   task automatic v(input string nm, input bit card, input logic [4:0] key, input logic [2:0] rsp,
                    input logic [15:0] p, input logic [2:0] op, input logic [15:0] amt,
                    input logic [15:0] np, input logic [4:0] pul);
      tbl.push_back(mk(card, key, rsp, p, op, amt, np, pul));
      tnm.push_back(nm);
   endtask

   task automatic run(input string nm, input bit card, input logic [4:0] key, input logic [2:0] rsp,
                      input logic [15:0] p, input logic [2:0] op, input logic [15:0] amt,
                      input logic [15:0] np, input logic [4:0] pul);
      apply(mk(card, key, rsp, p, op, amt, np, pul), nm);
   endtask

   // Scoreboard: one expected record per clock edge, compared just after it.
   always @(posedge clk) begin
      out_t  e;
      string n;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n = sbn.pop_front();
         chk(n, 64'(cur_out()), 64'(e));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; card_in = 1'b0; card_acc = 4'd0; lang_sel = 1'b0;
      key_valid = 1'b0; key_code = 4'd0;
      core_resp_valid = 1'b0; core_success = 1'b0; core_pin_ok = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset state", 64'(cur_out()), 64'(0));
      rst_n = 1'b1;

      t_acc = 4'd5; t_lang = 1'b1;
      v("insert",          1, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("pin d1",          1, k(1),     R0, 16'h0001, 0, 0,   0, P0);
      v("pin d2",          1, k(2),     R0, 16'h0012, 0, 0,   0, P0);
      v("pin d3",          1, k(3),     R0, 16'h0123, 0, 0,   0, P0);
      v("pin d4",          1, k(4),     R0, 16'h1234, 0, 0,   0, P0);
      v("pin 5th dropped", 1, k(5),     R0, 16'h1234, 0, 0,   0, P0);
      v("pin key D",       1, k(4'hD),  R0, 16'h1234, 0, 0,   0, P0);
      v("pin enter",       1, k(4'hA),  R0, 16'h1234, 0, 0,   0, P0);
      v("op early enter",  1, k(4'hA),  R0, 16'h1234, 0, 0,   0, P0);
      v("op 9 ignored",    1, k(9),     R0, 16'h1234, 0, 0,   0, P0);
      v("op 2",            1, k(2),     R0, 16'h1234, 2, 0,   0, P0);
      v("op enter",        1, k(4'hA),  R0, 16'h1234, 2, 0,   0, P0);
      v("amt 5",           1, k(5),     R0, 16'h1234, 2, 5,   0, P0);
      v("amt 50",          1, k(0),     R0, 16'h1234, 2, 50,  0, P0);
      v("amt 500",         1, k(0),     R0, 16'h1234, 2, 500, 0, P0);
      v("amt enter",       1, k(4'hA),  R0, 16'h1234, 2, 500, 0, TV);
      v("wait key ignored",1, k(7),     R0, 16'h1234, 2, 500, 0, TV);
      v("resp ok",         1, NK,       RS, 16'h1234, 0, 0,   0, OK);
      v("after resp",      1, NK,       R0, 16'h1234, 0, 0,   0, P0);
      v("op 2 again",      1, k(2),     R0, 16'h1234, 2, 0,   0, P0);
      v("op enter 2",      1, k(4'hA),  R0, 16'h1234, 2, 0,   0, P0);
      v("amt sat 9",       1, k(9),     R0, 16'h1234, 2, 9,    0, P0);
      v("amt sat 99",      1, k(9),     R0, 16'h1234, 2, 99,   0, P0);
      v("amt sat 999",     1, k(9),     R0, 16'h1234, 2, 999,  0, P0);
      v("amt sat 9999",    1, k(9),     R0, 16'h1234, 2, 9999, 0, P0);
      v("amt sat 5th",     1, k(9),     R0, 16'h1234, 2, 9999, 0, P0);
      v("amt clear",       1, k(4'hB),  R0, 16'h1234, 2, 0,   0, P0);
      v("amt zero enter",  1, k(4'hA),  R0, 16'h1234, 2, 0,   0, P0);
      v("amt 1",           1, k(1),     R0, 16'h1234, 2, 1,   0, P0);
      v("amt 1 enter",     1, k(4'hA),  R0, 16'h1234, 2, 1,   0, TV);
      v("pin bad 1 + key", 1, k(3),     RP, 16'h0000, 2, 1,   0, P0);
      v("retry d1",        1, k(1),     R0, 16'h0001, 2, 1,   0, P0);
      v("retry d2",        1, k(2),     R0, 16'h0012, 2, 1,   0, P0);
      v("short enter",     1, k(4'hA),  R0, 16'h0012, 2, 1,   0, P0);
      v("pin clear",       1, k(4'hB),  R0, 16'h0000, 2, 1,   0, P0);
      v("retry2 d1",       1, k(1),     R0, 16'h0001, 2, 1,   0, P0);
      v("retry2 d2",       1, k(2),     R0, 16'h0012, 2, 1,   0, P0);
      v("retry2 d3",       1, k(3),     R0, 16'h0123, 2, 1,   0, P0);
      v("retry2 d4",       1, k(4),     R0, 16'h1234, 2, 1,   0, P0);
      v("retry2 enter",    1, k(4'hA),  R0, 16'h1234, 2, 1,   0, P0);
      v("op 0",            1, k(0),     R0, 16'h1234, 0, 1,   0, P0);
      v("op 0 enter",      1, k(4'hA),  R0, 16'h1234, 0, 1,   0, TV);
      v("pin bad 2",       1, NK,       RP, 16'h0000, 0, 1,   0, P0);
      v("retry3 d1",       1, k(1),     R0, 16'h0001, 0, 1,   0, P0);
      v("retry3 d2",       1, k(2),     R0, 16'h0012, 0, 1,   0, P0);
      v("retry3 d3",       1, k(3),     R0, 16'h0123, 0, 1,   0, P0);
      v("retry3 d4",       1, k(4),     R0, 16'h1234, 0, 1,   0, P0);
      v("retry3 enter",    1, k(4'hA),  R0, 16'h1234, 0, 1,   0, P0);
      v("op 1",            1, k(1),     R0, 16'h1234, 1, 1,   0, P0);
      v("op 1 enter",      1, k(4'hA),  R0, 16'h1234, 1, 1,   0, TV);
      v("pin bad 3",       1, NK,       RP, 16'h1234, 1, 1,   0, P0);
      v("retain pulse",    1, NK,       R0, 16'h0000, 0, 0,   0, RT);
      v("idle after ret",  1, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("card removed",    0, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("reinsert",        1, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("s2 d1",           1, k(1),     R0, 16'h0001, 0, 0,   0, P0);
      v("s2 d2",           1, k(2),     R0, 16'h0012, 0, 0,   0, P0);
      v("s2 d3",           1, k(3),     R0, 16'h0123, 0, 0,   0, P0);
      v("s2 d4",           1, k(4),     R0, 16'h1234, 0, 0,   0, P0);
      v("s2 enter",        1, k(4'hA),  R0, 16'h1234, 0, 0,   0, P0);
      v("op 4",            1, k(4),     R0, 16'h1234, 4, 0,   0, P0);
      v("op 4 enter",      1, k(4'hA),  R0, 16'h1234, 4, 0,   0, P0);
      v("np d4",           1, k(4),     R0, 16'h1234, 4, 0, 16'h0004, P0);
      v("np d3",           1, k(3),     R0, 16'h1234, 4, 0, 16'h0043, P0);
      v("np d2",           1, k(2),     R0, 16'h1234, 4, 0, 16'h0432, P0);
      v("np d1",           1, k(1),     R0, 16'h1234, 4, 0, 16'h4321, P0);
      v("np 5th dropped",  1, k(9),     R0, 16'h1234, 4, 0, 16'h4321, P0);
      v("np clear",        1, k(4'hB),  R0, 16'h1234, 4, 0, 16'h0000, P0);
      v("np short enter",  1, k(4'hA),  R0, 16'h1234, 4, 0, 16'h0000, P0);
      v("np2 d4",          1, k(4),     R0, 16'h1234, 4, 0, 16'h0004, P0);
      v("np2 d3",          1, k(3),     R0, 16'h1234, 4, 0, 16'h0043, P0);
      v("np2 d2",          1, k(2),     R0, 16'h1234, 4, 0, 16'h0432, P0);
      v("np2 d1",          1, k(1),     R0, 16'h1234, 4, 0, 16'h4321, P0);
      v("np enter",        1, k(4'hA),  R0, 16'h1234, 4, 0, 16'h4321, TV);
      v("wait hold key",   1, k(5),     R0, 16'h1234, 4, 0, 16'h4321, TV);
      v("wait hold",       1, NK,       R0, 16'h1234, 4, 0, 16'h4321, TV);
      v("resp no success", 1, NK,       RF, 16'h1234, 0, 0,   0, P0);
      v("cancel opsel",    1, k(4'hC),  R0, 16'h1234, 0, 0,   0, P0);
      v("eject 1",         1, NK,       R0, 16'h0000, 0, 0,   0, EJ);
      v("idle after ej",   1, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("card out 1",      0, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("insert 3",        1, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("pin 7",           1, k(7),     R0, 16'h0007, 0, 0,   0, P0);
      v("cancel pin",      1, k(4'hC),  R0, 16'h0007, 0, 0,   0, P0);
      v("eject 2",         1, NK,       R0, 16'h0000, 0, 0,   0, EJ);
      v("card out 2",      0, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("insert 4",        1, NK,       R0, 16'h0000, 0, 0,   0, P0);
      v("pin 3",           1, k(3),     R0, 16'h0003, 0, 0,   0, P0);
      v("card pulled",     0, NK,       R0, 16'h0003, 0, 0,   0, P0);
      v("eject 3",         0, NK,       R0, 16'h0000, 0, 0,   0, EJ);
      v("idle 3",          0, NK,       R0, 16'h0000, 0, 0,   0, P0);

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], tnm[i]);

      // Inactivity timeout in OPSEL, new card with different account/language.
      t_acc = 4'd9; t_lang = 1'b0;
      run("to insert", 1, NK,      R0, 16'h0000, 0, 0, 0, P0);
      run("to d1",     1, k(1),    R0, 16'h0001, 0, 0, 0, P0);
      run("to d2",     1, k(2),    R0, 16'h0012, 0, 0, 0, P0);
      run("to d3",     1, k(3),    R0, 16'h0123, 0, 0, 0, P0);
      run("to d4",     1, k(4),    R0, 16'h1234, 0, 0, 0, P0);
      run("to enter",  1, k(4'hA), R0, 16'h1234, 0, 0, 0, P0);
      to_seen = 1'b0;
      wait_cyc = 0;
      for (int c = 1; c <= 1100 && !to_seen; c++) begin
         @(negedge clk);
         key_valid = 1'b0; core_resp_valid = 1'b0; card_in = 1'b1;
         @(posedge clk);
         #1;
         if (timeout) begin
            to_seen = 1'b1;
            wait_cyc = c;
         end
      end
      chk("timeout latency", 64'(wait_cyc), 64'(1000));
      chk("timeout pulse", 64'(cur_out()), 64'(mk(1, NK, R0, 16'h1234, 0, 0, 0, TO).o));
      run("to eject",  1, NK, R0, 16'h0000, 0, 0, 0, EJ);
      run("to idle",   1, NK, R0, 16'h0000, 0, 0, 0, P0);
      run("to cardout",0, NK, R0, 16'h0000, 0, 0, 0, P0);

      // Asynchronous reset while a request is pending.
      t_acc = 4'd6; t_lang = 1'b1;
      run("rs insert", 1, NK,      R0, 16'h0000, 0, 0, 0, P0);
      run("rs d1",     1, k(1),    R0, 16'h0001, 0, 0, 0, P0);
      run("rs d2",     1, k(2),    R0, 16'h0012, 0, 0, 0, P0);
      run("rs d3",     1, k(3),    R0, 16'h0123, 0, 0, 0, P0);
      run("rs d4",     1, k(4),    R0, 16'h1234, 0, 0, 0, P0);
      run("rs enter",  1, k(4'hA), R0, 16'h1234, 0, 0, 0, P0);
      run("rs op 1",   1, k(1),    R0, 16'h1234, 1, 0, 0, P0);
      run("rs wait",   1, k(4'hA), R0, 16'h1234, 1, 0, 0, TV);
      @(negedge clk);
      key_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      card_in = 1'b0;
      #1;
      chk("async reset", 64'(cur_out()), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      t_acc = 4'd0; t_lang = 1'b0;
      run("post-reset key", 0, k(1),    R0, 16'h0000, 0, 0, 0, P0);
      run("post-reset idle",0, k(4'hA), R0, 16'h0000, 0, 0, 0, P0);
      run("post-reset quiet",0, NK,     R0, 16'h0000, 0, 0, 0, P0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
